// File: rtl/if_fetch.sv
// Instruction fetch unit: issues one AXI-Lite read at a time and presents each
// returned word to decode until it is consumed, with redirect and beat-drop support.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_en_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_valid_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ar_q, ar_nxt;
  logic        drop, drop_nxt;
  logic [31:0] tgt;
  logic [31:0] fetch_x;
  logic        capture;
  logic        release_inst;

  assign tgt     = {redirect_pc_i[31:2], 2'b00};
  assign fetch_x = redirect_en_i ? tgt : pc;

  // Every entry into ADDR latches fetch_x as the request and advances pc past it.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ar_nxt       = ar_q;
    drop_nxt     = drop;
    capture      = 1'b0;
    release_inst = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = ADDR;
        ar_nxt    = fetch_x;
        pc_nxt    = fetch_x + 32'd4;
      end
      ADDR: begin
        // The pending request cannot be withdrawn, so its beat is marked for discard.
        if (redirect_en_i) begin
          pc_nxt   = tgt;
          drop_nxt = 1'b1;
        end
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        if (m_rvalid) begin
          if (drop || redirect_en_i) begin
            drop_nxt  = 1'b0;
            state_nxt = ADDR;
            ar_nxt    = fetch_x;
            pc_nxt    = fetch_x + 32'd4;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect_en_i) begin
          pc_nxt   = tgt;
          drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_en_i || !stall_i) begin
          release_inst = 1'b1;
          state_nxt    = ADDR;
          ar_nxt       = fetch_x;
          pc_nxt       = fetch_x + 32'd4;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ar_q         <= RESET_PC;
      drop         <= 1'b0;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
      inst_addr    <= 32'h0;
      inst_data    <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ar_q  <= ar_nxt;
      drop  <= drop_nxt;
      // Error responses are presented as a NOP so decode never sees garbage.
      if (capture) begin
        inst_addr    <= ar_q;
        inst_valid_o <= 1'b1;
        if (m_rresp == 2'b00) begin
          inst_data   <= m_rdata;
          fetch_err_o <= 1'b0;
        end else begin
          inst_data   <= 32'h0;
          fetch_err_o <= 1'b1;
        end
      end else if (release_inst) begin
        inst_valid_o <= 1'b0;
        fetch_err_o  <= 1'b0;
      end
    end
  end

  assign m_araddr  = ar_q;
  assign m_arprot  = 3'b100;
  assign m_arvalid = (state == ADDR);
  assign m_rready  = (state == DATA);

endmodule
